// File: rtl/ascon_perm_if.sv
// Host-side handshake bundle for the Ascon permutation sequencer.
// The AEAD mode FSM is the master, the sequencer is the slave.
interface ascon_perm_if;
  typedef logic [4:0][63:0] type_state;

  logic      start_i;
  logic      mode_i;
  type_state state_i;
  logic      ready_o;
  logic      busy_o;
  logic      valid_o;
  type_state state_o;

  modport master (
    output start_i,
    output mode_i,
    output state_i,
    input  ready_o,
    input  busy_o,
    input  valid_o,
    input  state_o
  );

  modport slave (
    input  start_i,
    input  mode_i,
    input  state_i,
    output ready_o,
    output busy_o,
    output valid_o,
    output state_o
  );
endinterface

// File: rtl/ascon_perm_sequencer.sv
// Iterative Ascon permutation controller: owns the 320-bit state and the
// round counter, and steps an external round datapath once per clock.
module ascon_perm_sequencer #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  ascon_perm_if.slave      host,
  input  logic [4:0][63:0] round_result_i,
  output logic [4:0][63:0] round_state_o,
  output logic [3:0]       round_o
);

  localparam logic [3:0] FIRST_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] FIRST_B = 4'(12 - ROUNDS_B);
  localparam logic [3:0] LAST    = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_e;

  fsm_e             fsm_q;
  logic [4:0][63:0] state_q;
  logic [3:0]       cnt_q;
  logic [3:0]       last_q;
  logic             ready_q;
  logic             busy_q;
  logic             valid_q;

  logic [3:0]       first_d;
  logic             load_d;

  assign first_d = host.mode_i ? FIRST_B : FIRST_A;
  assign load_d  = host.start_i && ready_q;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (fsm_q)
        IDLE, DONE: begin
          valid_q <= 1'b0;
          if (load_d) begin
            fsm_q   <= RUN;
            state_q <= host.state_i;
            cnt_q   <= first_d;
            last_q  <= LAST;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            fsm_q   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          state_q <= round_result_i;
          // the final round leaves the counter parked at its last index
          if (cnt_q == last_q) begin
            fsm_q   <= DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          fsm_q   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign round_state_o = state_q;
  assign round_o       = cnt_q;
  assign host.state_o  = state_q;
  assign host.ready_o  = ready_q;
  assign host.busy_o   = busy_q;
  assign host.valid_o  = valid_q;

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Randomised self-checking bench for ascon_perm_sequencer with a
// round-datapath stub that adds (round+1) to word 0.
module tb_ascon_perm_sequencer;
  typedef logic [4:0][63:0] st_t;

  localparam int RA = 12;
  localparam int RB = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ascon_perm_if bus();
  st_t        rres;
  st_t        rstate;
  logic [3:0] rnd;

  always_comb begin
    rres    = rstate;
    rres[0] = rstate[0] + 64'(rnd) + 64'd1;
  end

  ascon_perm_sequencer #(
    .ROUNDS_A(RA),
    .ROUNDS_B(RB)
  ) dut (
    .clock_i       (clk),
    .resetb_i      (rst_n),
    .host          (bus),
    .round_result_i(rres),
    .round_state_o (rstate),
    .round_o       (rnd)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [319:0] obs,
                     input logic [319:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic st_t ref_perm(input logic m, input st_t s);
    st_t r;
    int  n;
    r = s;
    n = m ? RB : RA;
    for (int k = 12 - n; k < 12; k++) r[0] = r[0] + 64'(k + 1);
    return r;
  endfunction

  function automatic st_t rnd_state();
    st_t r;
    for (int w = 0; w < 5; w++) r[w] = {$urandom, $urandom};
    return r;
  endfunction

  // Called at a negedge where the DUT is ready; returns at the DONE negedge.
  task automatic job(input logic m, input st_t s, input int poke,
                     output int vcyc, output st_t res);
    int  n;
    int  first;
    st_t exp;
    n     = m ? RB : RA;
    first = 12 - n;
    exp   = ref_perm(m, s);
    res   = exp;
    vcyc  = -1;
    chk("ready_pre", 320'(bus.ready_o), 320'(1));
    bus.start_i = 1'b1;
    bus.mode_i  = m;
    bus.state_i = s;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.mode_i  = 1'($urandom);
    bus.state_i = rnd_state();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        chk("round", 320'(rnd), 320'(first + i));
        chk("busy", 320'(bus.busy_o), 320'(1));
        chk("ready", 320'(bus.ready_o), 320'(0));
        chk("valid", 320'(bus.valid_o), 320'(0));
      end else begin
        chk("valid_end", 320'(bus.valid_o), 320'(1));
        chk("busy_end", 320'(bus.busy_o), 320'(0));
        chk("round_end", 320'(rnd), 320'(11));
        chk("state_o", bus.state_o, exp);
        vcyc = cyc;
      end
      if (i == poke) begin
        bus.start_i = 1'b1;
        bus.mode_i  = ~m;
        bus.state_i = rnd_state();
      end else begin
        bus.start_i = 1'b0;
      end
      if (i < n) @(negedge clk);
    end
  endtask

  st_t s0;
  st_t last_res;
  st_t tmp;
  int  v1;
  int  v2;

  initial begin
    s0[0] = 64'h00001000808C0001;
    s0[1] = 64'h6CB10AD9CA912F80;
    s0[2] = 64'h691AED630E81901F;
    s0[3] = 64'h0C4C36A20853217C;
    s0[4] = 64'h46487B3E06D9D7A8;
    bus.start_i = 1'b0;
    bus.mode_i  = 1'b0;
    bus.state_i = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", bus.state_o, '0);
    chk("rst_round", 320'(rnd), 320'(0));
    chk("rst_ready", 320'(bus.ready_o), 320'(1));
    chk("rst_busy", 320'(bus.busy_o), 320'(0));
    chk("rst_valid", 320'(bus.valid_o), 320'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    job(1'b0, s0, -1, v1, last_res);
    chk("p12_w0", 320'(bus.state_o[0]), 320'(64'h00001000808C004F));
    chk("p12_w4", 320'(bus.state_o[4]), 320'(s0[4]));
    @(negedge clk);
    job(1'b1, s0, -1, v1, last_res);
    chk("p6_w0", 320'(bus.state_o[0]), 320'(64'h00001000808C003A));
    @(negedge clk);

    job(1'b0, s0, 3, v1, last_res);
    chk("ignore_w0", 320'(bus.state_o[0]), 320'(64'h00001000808C004F));
    @(negedge clk);

    job(1'b0, s0, -1, v1, last_res);
    job(1'b0, rnd_state(), -1, v2, last_res);
    chk("b2b_gap", 320'(v2 - v1), 320'(13));

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_state", bus.state_o, last_res);
      chk("hold_valid", 320'(bus.valid_o), 320'(0));
      chk("hold_round", 320'(rnd), 320'(11));
    end

    bus.start_i = 1'b1;
    bus.mode_i  = 1'b0;
    bus.state_i = s0;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_state", bus.state_o, '0);
    chk("abort_round", 320'(rnd), 320'(0));
    chk("abort_ready", 320'(bus.ready_o), 320'(1));
    chk("abort_busy", 320'(bus.busy_o), 320'(0));
    chk("abort_valid", 320'(bus.valid_o), 320'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("abort_novalid", 320'(bus.valid_o), 320'(0));
      chk("abort_idle", 320'(bus.ready_o), 320'(1));
    end
    job(1'b0, s0, -1, v1, last_res);
    @(negedge clk);

    for (int t = 0; t < 25; t++) begin
      logic m;
      int   n;
      int   poke;
      m    = 1'($urandom);
      n    = m ? RB : RA;
      poke = ($urandom % 3 == 0) ? int'($urandom_range(0, n - 1)) : -1;
      tmp  = rnd_state();
      job(m, tmp, poke, v1, last_res);
      if ($urandom % 2 == 0) begin
        repeat (1 + $urandom % 3) @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ascon_perm_sequencer.md
Name: ascon_perm_sequencer

Overview:
- Iterative controller for the Ascon permutation: loads a 320-bit state, then drives the external round datapath one round per clock.
- The round datapath is constant_addition, then substitution, then diffusion.
- Supports p12 (rounds 0..11) and p6 (rounds 6..11).
- Owns the state register and the round counter that feeds round_i of constant_addition.
- Sits between the AEAD mode FSM (start/valid handshake) and the combinational round datapath.

Parameters:
- ROUNDS_A, 12, round count for mode_i=0 (p^a); first round index = 12-ROUNDS_A.
- ROUNDS_B, 6, round count for mode_i=1 (p^b); first round index = 12-ROUNDS_B.

Ports:
- clock_i  input  1  system clock, rising edge.
- resetb_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  request a permutation; accepted only when ready_o=1.
- mode_i  input  1  0=p12 (ROUNDS_A), 1=p6 (ROUNDS_B); sampled at acceptance.
- state_i  input  type_state  state to permute; sampled at acceptance.
- round_result_i  input  type_state  output of round datapath, computed from round_state_o and round_o.
- round_state_o  output  type_state  current state register, to round datapath input.
- round_o  output  4  round index to constant_addition.round_i.
- ready_o  output  1  controller can accept start_i.
- busy_o  output  1  rounds in progress.
- valid_o  output  1  one-cycle pulse: state_o holds the permuted result.
- state_o  output  type_state  result; equals the state register.

Behaviour:
- Reset (async, resetb_i=0):
  - FSM=IDLE; state register=0; counter=0.
  - round_o=0, ready_o=1, busy_o=0, valid_o=0, state_o=0.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - ready_o=1.
  - On start_i=1 at an edge: register<=state_i; counter<=12-ROUNDS(mode_i); last-index latch<=11; go to RUN.
- RUN:
  - busy_o=1, ready_o=0, round_o=counter.
  - Each edge: register<=round_result_i.
  - If counter==11: go to DONE; counter holds. Otherwise counter<=counter+1.
  - start_i is ignored; mode_i and state_i changes have no effect.
- DONE (exactly one cycle):
  - valid_o=1, ready_o=1, busy_o=0.
  - If start_i=1: new load as in IDLE, next state RUN (back-to-back, no bubble). Otherwise go to IDLE.
- Output hold: state_o/round_state_o keep the result in IDLE until the next accepted start.
- round_o rules:
  - round_o=counter at all times; in IDLE/DONE it holds its last value.
  - round_result_i is don't-care outside RUN.
- Latency:
  - start accepted at edge E0; round k is written at edge E0+k.
  - valid_o is high in the cycle after edge E0+ROUNDS: p12 → cycle 12 after acceptance, p6 → cycle 6.
- Throughput: one permutation per ROUNDS+1 cycles when back-to-back.
- Counter is 4 bits and never exceeds 11; no wrap-around.
- Reset asserted mid-RUN aborts immediately to reset values; no valid_o is produced.
- Simultaneous start_i and valid_o in DONE: the new job is accepted; the old result is visible only during that DONE cycle.

Test Plan:
- Bench stub for all scenarios: round_result_i = round_state_o with word[0] + (round_o+1).
- p12: reset, then start_i=1, mode_i=0, state_i[0]=64'h00001000808C0001 (other words 64'h6CB10AD9CA912F80, 64'h691AED630E81901F, 64'h0C4C36A20853217C, 64'h46487B3E06D9D7A8).
  - round_o steps 0..11 during RUN.
  - valid_o pulses 12 cycles after acceptance.
  - state_o[0]=64'h00001000808C004F (+78); words 1..4 unchanged.
- p6: same state_i, mode_i=1.
  - round_o steps 6..11.
  - valid_o at cycle 6.
  - state_o[0]=64'h00001000808C003A (+57).
- Busy ignore: pulse start_i=1 with a different state_i and mode_i at cycle 3 of a p12 run.
  - Result is identical to the p12 case; ready_o=0 throughout RUN.
- Back-to-back: start_i held high through the DONE cycle.
  - Second job loads with no idle cycle; second valid_o comes 13 cycles after the first.
- Reset mid-run: drive resetb_i=0 at cycle 5 of p12, then release.
  - Outputs go to reset values asynchronously; no valid_o; ready_o=1; a fresh p12 run then completes correctly.
- Idle hold: after valid_o, keep start_i=0 for 20 cycles.
  - state_o stays at the result; valid_o=0; round_o=11.
